eth_pause_tx_inserter: RTL and testbench
========================================

# eth_pause_tx_inserter

Transmit-side IEEE 802.3x MAC Control PAUSE generator for the 1G RGMII MAC path. It sits in the tx_clk domain between the TX FIFO output and the MAC's 8-bit AXI-stream transmit input. It forwards user frames unchanged and inserts 60-byte XOFF/XON PAUSE frames at frame boundaries on request. The MAC appends FCS and padding. Flow-control requests come from RX FIFO fill logic, which is already synchronized into tx_clk.

## Interface
Parameters:
- REFRESH_WIDTH, 24, width of refresh interval counter (tx_clk cycles).

Ports:
- tx_clk  in  1  transmit clock; all logic synchronous to it.
- tx_rst  in  1  reset, asynchronous, active-high.
- s_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  user frame stream from TX FIFO.
- m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  merged stream to MAC.
- pause_req  in  1  level; high = request peer to pause.
- cfg_pause_enable  in  1  enables PAUSE generation.
- cfg_src_mac  in  48  source MAC, [47:40] sent first.
- cfg_pause_quanta  in  16  XOFF quanta.
- cfg_refresh_interval  in  REFRESH_WIDTH  XOFF resend period while pause_req held; 0 = no refresh.
- pause_sent  out  1  one-cycle pulse on last beat of XOFF frame.
- xon_sent  out  1  one-cycle pulse on last beat of XON frame.
- busy  out  1  high in PASS or PAUSE.

## Operation
- Request tracking. req_q is the registered pause_req, reset 0.
  - Rising edge (pause_req & ~req_q) with enable: set xoff_pend, clear xon_pend.
  - Falling edge with enable: set xon_pend, clear xoff_pend.
  - cfg_pause_enable low: clear both pend flags and the refresh counter. A frame already in progress completes.
- Refresh counter. It increments each cycle while pause_req & enable & interval≠0. When count reaches interval-1, set xoff_pend and clear the counter. The counter also clears on completion of any XOFF frame.
- States:
  - IDLE: m_axis_tvalid=0, s_axis_tready=0.
    - If either pend flag is set, go to PAUSE. Latch quanta (cfg_pause_quanta for XOFF, 16'h0000 for XON), the frame type and cfg_src_mac. Clear the serviced pend flag.
    - Otherwise, if s_axis_tvalid, go to PASS.
    - Pending requests win over s_axis_tvalid in the same cycle.
  - PASS: combinational pass-through (m_* = s_*, s_axis_tready = m_axis_tready). On a handshake with tlast=1, go to IDLE. New pend flags wait.
  - PAUSE: s_axis_tready=0, m_axis_tvalid=1, tuser=0.
    - A 6-bit byte counter (0..59) advances on m_axis_tready.
    - Bytes 0–5: 01 80 C2 00 00 01. Bytes 6–11: latched src MAC. Bytes 12–13: 88 08. Bytes 14–15: 00 01. Bytes 16–17: quanta MSB first. Bytes 18–59: 00.
    - tlast=1 at byte 59. On that handshake: pulse pause_sent or xon_sent, reset the counter, go to IDLE.
- An edge arriving during PAUSE updates pend flags for the next frame; the current frame is never altered.

## Timing
- Reset values: state IDLE, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, m_axis_tuser 0, s_axis_tready 0, pause_sent 0, xon_sent 0, busy 0, pend flags 0, counters 0, req_q 0.
- pause_req high through reset deassertion is seen as a rising edge; XOFF is sent.
- Arbitration costs exactly one idle cycle (IDLE) before every frame, user or PAUSE.
- PASS adds zero latency; data, tlast and tuser are unmodified.
- PAUSE frame occupies 60 handshakes. Outputs are held stable while m_axis_tready=0 (AXIS rules).
- Request to first PAUSE byte: 2 cycles when idle (edge register, then IDLE decision). When PASS is active, the PAUSE frame starts after the user frame's tlast handshake plus one IDLE cycle.
- Reset mid-frame aborts immediately. The MAC sees tvalid drop without tlast; that is acceptable only because the MAC shares tx_rst.

## Test plan
- Passthrough: three 64-byte frames with varied tuser and pause_req=0 → identical bytes out, one idle cycle between frames, no pulses.
- XOFF when idle: quanta 16'hFFFF, src 02:00:00:00:00:01, pause_req 0→1 → bytes 01 80 C2 00 00 01 02 00 00 00 00 01 88 08 00 01 FF FF, then 42×00, tlast on byte 59, pause_sent pulses once.
- Mid-frame request: pause_req rises at byte 10 of a 100-byte user frame → user frame uninterrupted, then one idle cycle, then XOFF, then the next queued user frame.
- XON: pause_req 1→0 → 60-byte frame with bytes 16–17 = 00 00, xon_sent pulses, no pause_sent.
- Refresh under backpressure: interval=1000, pause_req held, random 50% m_axis_tready → XOFF resent repeatedly with content intact. No resend when interval=0 or cfg_pause_enable=0.
- Reset at byte 30 of XOFF: all outputs 0 during reset. After release with pause_req high, a fresh complete XOFF frame starts at byte 0.

Source files
------------

// File: rtl/eth_pause_tx_inserter.sv
// rtl/eth_pause_tx_inserter.sv - 802.3x PAUSE frame inserter on the MAC transmit stream
module eth_pause_tx_inserter #(
    parameter int REFRESH_WIDTH = 24
) (
    input  logic                     tx_clk,
    input  logic                     tx_rst,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tuser,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     pause_req,
    input  logic                     cfg_pause_enable,
    input  logic [47:0]              cfg_src_mac,
    input  logic [15:0]              cfg_pause_quanta,
    input  logic [REFRESH_WIDTH-1:0] cfg_refresh_interval,
    output logic                     pause_sent,
    output logic                     xon_sent,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_PAUSE
    } state_t;

    state_t                   state_q, state_d;
    logic                     req_q;
    logic                     xoff_pend_q, xoff_pend_d;
    logic                     xon_pend_q, xon_pend_d;
    logic [REFRESH_WIDTH-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [5:0]               byte_cnt_q, byte_cnt_d;
    logic [15:0]              quanta_q, quanta_d;
    logic [47:0]              src_mac_q, src_mac_d;
    logic                     is_xoff_q, is_xoff_d;

    logic       req_rise;
    logic       req_fall;
    logic       refresh_run;
    logic       refresh_hit;
    logic       pause_last;
    logic [7:0] pause_byte;

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            xoff_pend_q   <= 1'b0;
            xon_pend_q    <= 1'b0;
            refresh_cnt_q <= '0;
            byte_cnt_q    <= '0;
            quanta_q      <= '0;
            src_mac_q     <= '0;
            is_xoff_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= pause_req;
            xoff_pend_q   <= xoff_pend_d;
            xon_pend_q    <= xon_pend_d;
            refresh_cnt_q <= refresh_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            quanta_q      <= quanta_d;
            src_mac_q     <= src_mac_d;
            is_xoff_q     <= is_xoff_d;
        end
    end

    assign req_rise    = pause_req & ~req_q;
    assign req_fall    = ~pause_req & req_q;
    assign refresh_run = pause_req & cfg_pause_enable & (cfg_refresh_interval != '0);
    assign refresh_hit = refresh_run &&
                         (refresh_cnt_q == cfg_refresh_interval - REFRESH_WIDTH'(1));
    assign pause_last  = (byte_cnt_q == 6'd59);
    assign busy        = (state_q != ST_IDLE);

    // MAC Control PAUSE layout; everything past the quanta field is zero
    always_comb begin
        pause_byte = 8'h00;
        case (byte_cnt_q)
            6'd0:    pause_byte = 8'h01;
            6'd1:    pause_byte = 8'h80;
            6'd2:    pause_byte = 8'hC2;
            6'd5:    pause_byte = 8'h01;
            6'd6:    pause_byte = src_mac_q[47:40];
            6'd7:    pause_byte = src_mac_q[39:32];
            6'd8:    pause_byte = src_mac_q[31:24];
            6'd9:    pause_byte = src_mac_q[23:16];
            6'd10:   pause_byte = src_mac_q[15:8];
            6'd11:   pause_byte = src_mac_q[7:0];
            6'd12:   pause_byte = 8'h88;
            6'd13:   pause_byte = 8'h08;
            6'd15:   pause_byte = 8'h01;
            6'd16:   pause_byte = quanta_q[15:8];
            6'd17:   pause_byte = quanta_q[7:0];
            default: pause_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        xoff_pend_d   = xoff_pend_q;
        xon_pend_d    = xon_pend_q;
        refresh_cnt_d = refresh_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        quanta_d      = quanta_q;
        src_mac_d     = src_mac_q;
        is_xoff_d     = is_xoff_q;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = 1'b0;
        pause_sent    = 1'b0;
        xon_sent      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xoff_pend_q) begin
                    state_d     = ST_PAUSE;
                    quanta_d    = cfg_pause_quanta;
                    src_mac_d   = cfg_src_mac;
                    is_xoff_d   = 1'b1;
                    xoff_pend_d = 1'b0;
                end else if (xon_pend_q) begin
                    state_d    = ST_PAUSE;
                    quanta_d   = 16'h0000;
                    src_mac_d  = cfg_src_mac;
                    is_xoff_d  = 1'b0;
                    xon_pend_d = 1'b0;
                end else if (s_axis_tvalid) begin
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                m_axis_tdata  = pause_byte;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = pause_last;
                if (m_axis_tready) begin
                    if (pause_last) begin
                        byte_cnt_d = '0;
                        state_d    = ST_IDLE;
                        pause_sent = is_xoff_q;
                        xon_sent   = ~is_xoff_q;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Edges are applied after servicing so a request landing on the
        // IDLE decision cycle is queued for the next frame, not lost.
        if (req_rise) begin
            xoff_pend_d = 1'b1;
            xon_pend_d  = 1'b0;
        end else if (req_fall) begin
            xon_pend_d  = 1'b1;
            xoff_pend_d = 1'b0;
        end

        if (refresh_run) begin
            refresh_cnt_d = refresh_hit ? '0 : refresh_cnt_q + REFRESH_WIDTH'(1);
        end else begin
            refresh_cnt_d = '0;
        end
        if (refresh_hit) begin
            xoff_pend_d = 1'b1;
        end
        if (pause_sent) begin
            refresh_cnt_d = '0;
        end

        if (!cfg_pause_enable) begin
            xoff_pend_d   = 1'b0;
            xon_pend_d    = 1'b0;
            refresh_cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_eth_pause_tx_inserter.sv
// tb/tb_eth_pause_tx_inserter.sv - directed bench for the PAUSE inserter
module tb_eth_pause_tx_inserter;

    logic        tx_clk;
    logic        tx_rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        pause_req;
    logic        cfg_pause_enable;
    logic [47:0] cfg_src_mac;
    logic [15:0] cfg_pause_quanta;
    logic [23:0] cfg_refresh_interval;
    logic        pause_sent;
    logic        xon_sent;
    logic        busy;

    eth_pause_tx_inserter #(.REFRESH_WIDTH(24)) dut (
        .tx_clk               (tx_clk),
        .tx_rst               (tx_rst),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tuser         (s_axis_tuser),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tuser         (m_axis_tuser),
        .pause_req            (pause_req),
        .cfg_pause_enable     (cfg_pause_enable),
        .cfg_src_mac          (cfg_src_mac),
        .cfg_pause_quanta     (cfg_pause_quanta),
        .cfg_refresh_interval (cfg_refresh_interval),
        .pause_sent           (pause_sent),
        .xon_sent             (xon_sent),
        .busy                 (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_pause = 0;
    int n_xon   = 0;
    int p0;
    int x0;
    logic rand_rdy = 1'b0;

    logic [9:0] cap_q[$];
    logic [9:0] exp_q[$];
    int         gap_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        tx_clk = 1'b0;
        forever #5 tx_clk = ~tx_clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge tx_clk);
            #1;
            if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    // Capture every output handshake; record idle gaps and AXIS hold rule
    int         gap_cnt = 0;
    logic       in_frame = 1'b0;
    logic       stall_valid = 1'b0;
    logic [9:0] stall_beat = '0;
    always @(negedge tx_clk) begin
        if (tx_rst) begin
            gap_cnt     = 0;
            in_frame    = 1'b0;
            stall_valid = 1'b0;
        end else begin
            if (stall_valid) begin
                check("hold_valid", m_axis_tvalid, 1'b1);
                check("hold_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, stall_beat);
            end
            stall_valid = m_axis_tvalid && !m_axis_tready;
            stall_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            if (m_axis_tvalid && m_axis_tready) begin
                if (!in_frame) begin
                    gap_q.push_back(gap_cnt);
                    in_frame = 1'b1;
                end
                cap_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
                if (m_axis_tlast) begin
                    in_frame = 1'b0;
                    gap_cnt  = 0;
                end
            end else if (!m_axis_tvalid) begin
                gap_cnt++;
            end
            if (pause_sent) n_pause++;
            if (xon_sent) n_xon++;
        end
    end

    function automatic logic [9:0] user_beat(input int len, input int seed, input int upos, input int i);
        return {(i == upos), (i == len - 1), 8'(seed * 7 + i)};
    endfunction

    task automatic push_user(input int len, input int seed, input int upos);
        for (int i = 0; i < len; i++) exp_q.push_back(user_beat(len, seed, upos, i));
    endtask

    task automatic push_pause(input logic [15:0] q, input logic [47:0] mac);
        logic [7:0] hdr[18];
        hdr = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01,
                mac[47:40], mac[39:32], mac[31:24], mac[23:16], mac[15:8], mac[7:0],
                8'h88, 8'h08, 8'h00, 8'h01, q[15:8], q[7:0]};
        for (int i = 0; i < 60; i++)
            exp_q.push_back({1'b0, (i == 59), (i < 18) ? hdr[i] : 8'h00});
    endtask

    task automatic send_frame(input int len, input int seed, input int upos);
        int   i = 0;
        int   guard = 0;
        logic hs;
        {s_axis_tuser, s_axis_tlast, s_axis_tdata} = user_beat(len, seed, upos, 0);
        s_axis_tvalid = 1'b1;
        while (i < len && guard < 4000) begin
            @(negedge tx_clk);
            hs = s_axis_tready;
            @(posedge tx_clk);
            #1;
            guard++;
            if (hs) begin
                i++;
                if (i < len) {s_axis_tuser, s_axis_tlast, s_axis_tdata} = user_beat(len, seed, upos, i);
                else s_axis_tvalid = 1'b0;
            end
        end
        if (i < len) check("src_timeout", i, len);
    endtask

    task automatic wait_cap(input string tag, input int n, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(posedge tx_clk);
            #1;
            if (cap_q.size() >= n) break;
        end
        check(tag, cap_q.size() >= n, 1'b1);
    endtask

    task automatic cmp_frames(input string tag);
        int n;
        check({tag, "_len"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, cap_q[i], exp_q[i]);
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_all();
        cap_q.delete();
        exp_q.delete();
        gap_q.delete();
    endtask

    initial begin
        tx_rst               = 1'b1;
        s_axis_tdata         = 8'h00;
        s_axis_tvalid        = 1'b1;
        s_axis_tlast         = 1'b0;
        s_axis_tuser         = 1'b0;
        m_axis_tready        = 1'b1;
        pause_req            = 1'b0;
        cfg_pause_enable     = 1'b1;
        cfg_src_mac          = 48'h02_00_00_00_00_01;
        cfg_pause_quanta     = 16'hFFFF;
        cfg_refresh_interval = 24'd0;

        repeat (3) @(posedge tx_clk);
        #1;
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_m_tdata", m_axis_tdata, 8'h00);
        check("rst_m_tlast", m_axis_tlast, 1'b0);
        check("rst_m_tuser", m_axis_tuser, 1'b0);
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pulses", {pause_sent, xon_sent}, 2'b00);
        s_axis_tvalid = 1'b0;
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        repeat (3) @(posedge tx_clk);
        #1;

        // Passthrough of three frames with different tuser placement
        clear_all();
        p0 = n_pause;
        x0 = n_xon;
        push_user(64, 1, -1);
        push_user(64, 2, 63);
        push_user(64, 3, 5);
        send_frame(64, 1, -1);
        send_frame(64, 2, 63);
        send_frame(64, 3, 5);
        wait_cap("pass_wait", 192, 500);
        cmp_frames("pass_beat");
        check("pass_gap1", gap_q.size() > 1 ? gap_q[1] : -1, 1);
        check("pass_gap2", gap_q.size() > 2 ? gap_q[2] : -1, 1);
        check("pass_pulses", (n_pause - p0) + (n_xon - x0), 0);

        // XOFF from idle, with two-cycle request latency
        clear_all();
        p0 = n_pause;
        x0 = n_xon;
        pause_req = 1'b1;
        @(posedge tx_clk);
        #1;
        check("xoff_lat1_tvalid", m_axis_tvalid, 1'b0);
        @(posedge tx_clk);
        #1;
        check("xoff_lat2_tvalid", m_axis_tvalid, 1'b1);
        check("xoff_lat2_tdata", m_axis_tdata, 8'h01);
        check("xoff_busy", busy, 1'b1);
        check("xoff_s_tready", s_axis_tready, 1'b0);
        push_pause(16'hFFFF, 48'h02_00_00_00_00_01);
        wait_cap("xoff_wait", 60, 200);
        cmp_frames("xoff_beat");
        check("xoff_pause_sent", n_pause - p0, 1);
        check("xoff_xon_sent", n_xon - x0, 0);

        // XON on release
        p0 = n_pause;
        x0 = n_xon;
        pause_req = 1'b0;
        push_pause(16'h0000, 48'h02_00_00_00_00_01);
        wait_cap("xon_wait", 60, 200);
        cmp_frames("xon_beat");
        check("xon_xon_sent", n_xon - x0, 1);
        check("xon_pause_sent", n_pause - p0, 0);

        // Request during a user frame waits for its end
        clear_all();
        p0 = n_pause;
        push_user(100, 4, 99);
        push_pause(16'hFFFF, 48'h02_00_00_00_00_01);
        push_user(64, 5, -1);
        fork
            begin
                send_frame(100, 4, 99);
                send_frame(64, 5, -1);
            end
            begin
                wait_cap("mid_arm", 10, 300);
                pause_req = 1'b1;
            end
        join
        wait_cap("mid_wait", 224, 1000);
        cmp_frames("mid_beat");
        check("mid_gap_xoff", gap_q.size() > 1 ? gap_q[1] : -1, 1);
        check("mid_gap_user", gap_q.size() > 2 ? gap_q[2] : -1, 1);
        check("mid_pause_sent", n_pause - p0, 1);

        // Refresh under random backpressure
        pause_req = 1'b0;
        push_pause(16'h0000, 48'h02_00_00_00_00_01);
        wait_cap("rf_xon_wait", 60, 200);
        cmp_frames("rf_xon_beat");
        clear_all();
        cfg_pause_quanta     = 16'h1234;
        cfg_src_mac          = 48'h0A_0B_0C_0D_0E_0F;
        cfg_refresh_interval = 24'd1000;
        rand_rdy             = 1'b1;
        p0                   = n_pause;
        pause_req            = 1'b1;
        for (int k = 0; k < 3; k++) push_pause(16'h1234, 48'h0A_0B_0C_0D_0E_0F);
        wait_cap("rf_wait", 180, 6000);
        cfg_refresh_interval = 24'd0;
        cmp_frames("rf_beat");
        check("rf_gap2", gap_q.size() > 1 ? gap_q[1] : -1, 1001);
        check("rf_gap3", gap_q.size() > 2 ? gap_q[2] : -1, 1001);
        check("rf_pause_sent", n_pause - p0, 3);
        repeat (2500) @(posedge tx_clk);
        #1;
        check("rf_zero_interval", cap_q.size(), 0);
        cfg_refresh_interval = 24'd1000;
        cfg_pause_enable     = 1'b0;
        repeat (2500) @(posedge tx_clk);
        #1;
        check("rf_disabled", cap_q.size(), 0);

        // Reset in the middle of an XOFF frame
        pause_req = 1'b0;
        rand_rdy  = 1'b0;
        @(posedge tx_clk);
        #1;
        m_axis_tready    = 1'b1;
        cfg_pause_enable = 1'b1;
        cfg_pause_quanta = 16'hABCD;
        clear_all();
        pause_req = 1'b1;
        wait_cap("mrst_arm", 30, 200);
        tx_rst = 1'b1;
        #1;
        check("mrst_m_tvalid", m_axis_tvalid, 1'b0);
        check("mrst_m_tdata", m_axis_tdata, 8'h00);
        check("mrst_m_tlast", m_axis_tlast, 1'b0);
        check("mrst_busy", busy, 1'b0);
        clear_all();
        repeat (3) @(posedge tx_clk);
        #1;
        p0     = n_pause;
        tx_rst = 1'b0;
        push_pause(16'hABCD, 48'h0A_0B_0C_0D_0E_0F);
        wait_cap("mrst_wait", 60, 200);
        cmp_frames("mrst_beat");
        check("mrst_pause_sent", n_pause - p0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
